ram_dp_be: RTL and testbench

Parametrised simple dual-port RAM for the MiniMicro memory subsystem, with one write port and one read port. It adds per-byte write enables, a registered read with a valid strobe, and write-first forwarding on address collision. It also runs a hardware clear sequence after reset, which zeroes every word before the RAM accepts accesses. It replaces the single-port 32x32 RAM for instruction and data storage.

---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_clear_ctrl.sv | 44 ++++
 rtl/ram_dp_be.sv | 141 ++++++++++++++
 tb/tb_ram_dp_be.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and defaults for the byte-enable dual-port RAM.
package ram_pkg;

  typedef enum logic {RAM_CLEAR, RAM_READY} ram_state_t;

  localparam int RAM_DATA_W = 32;
  localparam int RAM_DEPTH  = 32;
  localparam int RAM_BYTE_W = 8;

  // Address width for a given depth, never narrower than one bit.
  function automatic int ram_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset clear sequencer: walks every word address once, then releases busy.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH  = RAM_DEPTH,
  parameter int ADDR_W = ram_addr_w(RAM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  ram_state_t        state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RAM_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        RAM_CLEAR: begin
          if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= RAM_READY;
            busy_q  <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        RAM_READY: state_q <= RAM_READY;
        default:   state_q <= RAM_CLEAR;
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = (state_q == RAM_CLEAR);
  assign clr_addr = clr_cnt_q;

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte enables, write-first forwarding and a post-reset clear.
// Define RAM_OUTREG_EN to add a second output register (read latency 2).
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int  DATA_WIDTH = RAM_DATA_W,
  parameter int  DEPTH      = RAM_DEPTH,
  parameter int  BYTE_W     = RAM_BYTE_W,
  localparam int NB         = DATA_WIDTH / BYTE_W,
  localparam int ADDR_W     = ram_addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [NB-1:0]         wr_be,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy
);

  logic                  clr_we;
  logic [ADDR_W-1:0]     clr_addr;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_wa;
  logic [NB-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] mem_wd;

  logic                  wr_ok;
  logic                  rd_ok;
  logic                  rd_fire;
  logic [ADDR_W-1:0]     rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] rd_data_p1_d, rd_data_p1_q;
  logic                  rd_vld_p1_d, rd_vld_p1_q;

  function automatic logic [DATA_WIDTH-1:0] lane_merge(input logic [DATA_WIDTH-1:0] old_w,
                                                       input logic [DATA_WIDTH-1:0] new_w,
                                                       input logic [NB-1:0]         be);
    lane_merge = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) lane_merge[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
  endfunction

  ram_clear_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_ok = (32'(wr_addr) < 32'(DEPTH));
  assign rd_ok = (32'(rd_addr) < 32'(DEPTH));

  // Clear writes own the array while busy; port writes outside the array are dropped.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_be = '0;
    mem_wd = '0;
    if (clr_we) begin
      mem_we = 1'b1;
      mem_wa = clr_addr;
      mem_be = '1;
    end else if (wr_en && wr_ok) begin
      mem_we = 1'b1;
      mem_wa = wr_addr;
      mem_be = wr_be;
      mem_wd = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem_q[mem_wa][i*BYTE_W +: BYTE_W] <= mem_wd[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Stage 1: array read with per-lane write-first forwarding on address collision.
  always_comb begin
    rd_fire = rd_en && !busy;
    rd_idx  = rd_ok ? rd_addr : '0;
    rd_word = rd_ok ? mem_q[rd_idx] : '0;
    if (wr_en && wr_ok && !busy && (wr_addr == rd_addr)) begin
      rd_word = lane_merge(rd_word, wr_data, wr_be);
    end
    rd_data_p1_d = busy ? '0 : (rd_fire ? rd_word : rd_data_p1_q);
    rd_vld_p1_d  = rd_fire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_p1_q <= '0;
      rd_vld_p1_q  <= 1'b0;
    end else begin
      rd_data_p1_q <= rd_data_p1_d;
      rd_vld_p1_q  <= rd_vld_p1_d;
    end
  end

`ifdef RAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] rd_data_p2_d, rd_data_p2_q;
  logic                  rd_vld_p2_d, rd_vld_p2_q;

  // Stage 2: output register, flushed while the clear runs.
  always_comb begin
    rd_data_p2_d = busy ? '0 : rd_data_p1_q;
    rd_vld_p2_d  = !busy && rd_vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_p2_q <= '0;
      rd_vld_p2_q  <= 1'b0;
    end else begin
      rd_data_p2_q <= rd_data_p2_d;
      rd_vld_p2_q  <= rd_vld_p2_d;
    end
  end

  assign rd_data  = rd_data_p2_q;
  assign rd_valid = rd_vld_p2_q;
`else
  assign rd_data  = rd_data_p1_q;
  assign rd_valid = rd_vld_p1_q;
`endif

endmodule

// File: tb/tb_ram_dp_be.sv
// Scoreboard bench for ram_dp_be: a DEPTH=32 and a DEPTH=20 instance share one stimulus stream.
module tb_ram_dp_be;

`ifdef RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic        busy_a, busy_b;

  always #5 clk = ~clk;

  ram_dp_be #(.DATA_WIDTH(32), .DEPTH(32), .BYTE_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .busy(busy_a)
  );

  ram_dp_be #(.DATA_WIDTH(32), .DEPTH(20), .BYTE_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .busy(busy_b)
  );

  // Reference model state, one slot per instance.
  int          dep [2] = '{32, 20};
  logic [31:0] mmem [2][32];
  int          clear_left [2] = '{0, 0};
  logic        busy_exp [2];
  logic [31:0] last [2];
  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  bit          chk_en = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic model_step(input int k);
    exp_t e;
    if (!rst_n) begin
      clear_left[k] = dep[k];
      busy_exp[k]   = 1'b1;
      last[k]       = 32'h0;
      for (int j = 0; j < 32; j++) mmem[k][j] = 32'h0;
      if (k == 0) q0.delete(); else q1.delete();
      chk_en = 1'b1;
    end else if (clear_left[k] > 0) begin
      clear_left[k] = clear_left[k] - 1;
      busy_exp[k]   = (clear_left[k] > 0);
    end else begin
      busy_exp[k] = 1'b0;
      if (wr_en && (int'(wr_addr) < dep[k])) begin
        for (int i = 0; i < 4; i++)
          if (wr_be[i]) mmem[k][wr_addr][i*8 +: 8] = wr_data[i*8 +: 8];
      end
      if (rd_en) begin
        e.data = (int'(rd_addr) < dep[k]) ? mmem[k][rd_addr] : 32'h0;
        e.due  = cyc + LAT - 1;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    model_step(0);
    model_step(1);
  end

  task automatic fail_line(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_fail++;
    $display("FAIL %s port%0d cyc=%0d: got %h expected %h", name, k, cyc, got, exp);
  endtask

  task automatic mon(input int k, input logic v, input logic [31:0] d, input logic b);
    exp_t e;
    int   qn;
    qn = (k == 0) ? q0.size() : q1.size();
    n_chk++;
    if (b !== busy_exp[k]) fail_line("busy", k, 32'(b), 32'(busy_exp[k]));
    if (v === 1'b1) begin
      n_chk++;
      if (qn == 0) begin
        fail_line("unexpected_valid", k, d, 32'h0);
      end else begin
        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
        if (e.due != cyc) fail_line("read_latency", k, 32'(cyc), 32'(e.due));
        else if (d !== e.data) fail_line("read_data", k, d, e.data);
        last[k] = e.data;
      end
    end else begin
      if (qn > 0) begin
        if (k == 0) e = q0[0]; else e = q1[0];
        if (e.due <= cyc) begin
          n_chk++;
          fail_line("missing_valid", k, 32'(v), 32'h1);
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
      n_chk++;
      if (v !== 1'b0) fail_line("valid_x", k, 32'(v), 32'h0);
      else if (d !== last[k]) fail_line("hold_data", k, d, last[k]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      mon(0, rd_valid_a, rd_data_a, busy_a);
      mon(1, rd_valid_b, rd_data_b, busy_b);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic re, input logic [4:0] ra);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic rand_op();
    logic [4:0] wa;
    wa = 5'($urandom_range(31, 0));
    drive(1'($urandom_range(1, 0)), wa, 4'($urandom_range(15, 0)), $urandom,
          1'($urandom_range(1, 0)),
          ($urandom_range(3, 0) == 0) ? wa : 5'($urandom_range(31, 0)));
  endtask

  task automatic count_busy();
    int na, nb, n;
    na = 0; nb = 0; n = 0;
    while ((busy_a || busy_b) && n < 100) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      n++;
      @(negedge clk);
    end
    chk("busy_cycles_d32", 32'(na), 32'd32);
    chk("busy_cycles_d20", 32'(nb), 32'd20);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy_a), 32'h1);
    chk("reset_rd_valid", 32'(rd_valid_a), 32'h0);
    chk("reset_rd_data", rd_data_a, 32'h0);

    rst_n = 1'b1;
    count_busy();

    for (int a = 0; a < 32; a++) drive(1'b0, '0, '0, '0, 1'b1, 5'(a));
    drain();

    drive(1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 1'b0, '0);
    drive(1'b1, 5'd5, 4'b0101, 32'h11223344, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 5'd5);
    idle();
    repeat (LAT - 1) @(negedge clk);
    chk("byte_enable_a", rd_data_a, 32'hDE22BE44);
    chk("byte_enable_b", rd_data_b, 32'hDE22BE44);
    drain();

    drive(1'b1, 5'd7, 4'hF, 32'h12345678, 1'b0, '0);
    drive(1'b1, 5'd7, 4'b0011, 32'hAABBCCDD, 1'b1, 5'd7);
    idle();
    repeat (LAT - 1) @(negedge clk);
    chk("collision_fwd", rd_data_a, 32'h1234CCDD);
    drain();

    for (int a = 0; a < 4; a++) drive(1'b1, 5'(a), 4'hF, 32'h10 + 32'(a), 1'b0, '0);
    for (int a = 0; a < 4; a++) drive(1'b0, '0, '0, '0, 1'b1, 5'(a));
    drain();

    drive(1'b1, 5'd9, 4'hF, 32'hCAFE0000, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 5'd9);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_rd_valid", 32'(rd_valid_a), 32'h0);
    chk("midreset_rd_data", rd_data_a, 32'h0);
    chk("midreset_busy", 32'(busy_a), 32'h1);
    rst_n = 1'b1;
    for (int i = 0; i < 100 && busy_a; i++) rand_op();
    drain();
    drive(1'b0, '0, '0, '0, 1'b1, 5'd9);
    idle();
    repeat (LAT - 1) @(negedge clk);
    chk("cleared_addr9", rd_data_a, 32'h0);
    drain();
    for (int a = 0; a < 32; a++) drive(1'b0, '0, '0, '0, 1'b1, 5'(a));
    drain();

    drive(1'b1, 5'd25, 4'hF, 32'h5A5A5A5A, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 5'd25);
    idle();
    repeat (LAT - 1) @(negedge clk);
    chk("oor_read_valid_d20", 32'(rd_valid_b), 32'h1);
    chk("oor_read_data_d20", rd_data_b, 32'h0);
    chk("inrange_read_d32", rd_data_a, 32'h5A5A5A5A);
    drain();
    for (int a = 0; a < 32; a++) drive(1'b0, '0, '0, '0, 1'b1, 5'(a));
    drain();

    for (int i = 0; i < 600; i++) begin
      if (i == 300) rst_n = 1'b0;
      if (i == 302) rst_n = 1'b1;
      rand_op();
    end
    drain();
    for (int a = 0; a < 32; a++) drive(1'b0, '0, '0, '0, 1'b1, 5'(a));
    drain();

    chk("scoreboard_empty_a", 32'(q0.size()), 32'h0);
    chk("scoreboard_empty_b", 32'(q1.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
